// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the prefetching fetch stage.
// FSM state encoding, default geometry, queue entry layout helpers.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   localparam int ADDR_W_DEF = 16;
   localparam int INST_W_DEF = 16;
   localparam int PC_INC_DEF = 2;

   // Entry layout at the default widths: instruction in the upper bits,
   // its address in the lower bits.
   typedef struct packed {
      logic [INST_W_DEF-1:0] inst;
      logic [ADDR_W_DEF-1:0] pc;
   } fetch_entry_t;

   function automatic int entry_w(input int inst_w, input int addr_w);
      return inst_w + addr_w;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH x WIDTH synchronous queue with flush and occupancy.
// Ports: clk, rst (sync, active-low), flush, push/wdata, pop/rdata, count.
module fetch_fifo
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL) || do_pop);

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + (PTR_W+1)'(do_push)
                        - (PTR_W+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC holder, imem req/ack fetcher and prefetch queue.
// Ports: clk, rst (sync, active-low); redirect_valid/redirect_pc;
//   imem_req/imem_addr/imem_ack/imem_rdata; inst_valid/inst_ready/
//   inst_data/inst_pc/inst_pc_next to decode; err.
// Option: FETCH_ALIGN_CHECK_EN flags misaligned redirects on err.
module fetch_prefetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                INST_W   = INST_W_DEF,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_INC   = PC_INC_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [ADDR_W-1:0] inst_pc_next,
   output logic              err
);

   localparam int ENT_W = entry_w(INST_W, ADDR_W);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

   fetch_state_t      state;
   fetch_state_t      state_n;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] fetch_pc_n;
   logic [ADDR_W-1:0] drop_addr;
   logic [ADDR_W-1:0] drop_addr_n;
   logic [CNT_W-1:0]  count;
   logic [ENT_W-1:0]  head;
   logic              push;
   logic              pop;
   logic              err_q;
   logic [CNT_W:0]    occ;
   logic [CNT_W:0]    after;

   assign pop = inst_valid & inst_ready;

   // An issued request already owns a slot, so occupancy counts it.
   assign occ = {1'b0, count}
              + {{CNT_W{1'b0}}, (state == REQ)};

   // Occupancy once this cycle's ack is pushed and any pop retires.
   assign after = {1'b0, count} + (CNT_W+1)'(1)
                - {{CNT_W{1'b0}}, pop};

`ifdef FETCH_ALIGN_CHECK_EN
   logic misaligned;

   assign misaligned = redirect_valid
                    && ((redirect_pc % INC) != '0);

   always_ff @(posedge clk) begin
      if (!rst)
         err_q <= 1'b0;
      else if (misaligned)
         err_q <= 1'b1;
   end
`else
   assign err_q = 1'b0;
`endif

   assign err = err_q;

   always_comb begin
      state_n     = state;
      fetch_pc_n  = fetch_pc;
      drop_addr_n = drop_addr;
      push        = 1'b0;
      unique case (state)
         IDLE: begin
            if (!redirect_valid && !err_q
                && (occ < DEPTH_L))
               state_n = REQ;
         end
         REQ: begin
            if (redirect_valid) begin
               if (imem_ack) begin
                  state_n = IDLE;
               end else begin
                  // Old read must still complete on its address.
                  state_n     = DROP;
                  drop_addr_n = fetch_pc;
               end
            end else if (imem_ack) begin
               push       = 1'b1;
               fetch_pc_n = fetch_pc + INC;
               state_n    = (after < DEPTH_L) ? REQ : IDLE;
            end
         end
         DROP: begin
            if (imem_ack)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (redirect_valid)
         fetch_pc_n = redirect_pc;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         drop_addr <= '0;
      end else begin
         state     <= state_n;
         fetch_pc  <= fetch_pc_n;
         drop_addr <= drop_addr_n;
      end
   end

   assign imem_req  = (state != IDLE);
   assign imem_addr = (state == DROP) ? drop_addr : fetch_pc;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (push),
      .wdata ({imem_rdata, fetch_pc}),
      .pop   (pop),
      .rdata (head),
      .count (count)
   );

   assign inst_valid   = (count != '0);
   assign inst_data    = head[ENT_W-1 -: INST_W];
   assign inst_pc      = head[ADDR_W-1:0];
   assign inst_pc_next = inst_pc + INC;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: scoreboard bench for the prefetching fetch stage.
// A latency-programmable memory answers requests; decode side is checked.
module tb_fetch_prefetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [15:0] inst_data;
   logic [15:0] inst_pc;
   logic [15:0] inst_pc_next;
   logic        err;

   int checks   = 0;
   int failures = 0;
   int lat      = 0;
   int wait_cnt = 0;

   logic [15:0] exp_q[$];
   logic [15:0] ack_log[$];

   fetch_prefetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_pc_next   (inst_pc_next),
      .err            (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] data_of(input logic [15:0] pc);
      return {pc[7:0], pc[15:8]} ^ 16'hC3A5;
   endfunction

   // Memory model: ack after lat waiting cycles, seen before a posedge.
   always @(negedge clk) begin
      if (imem_req === 1'b1) begin
         if (wait_cnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = data_of(imem_addr);
            ack_log.push_back(imem_addr);
            wait_cnt   = 0;
         end else begin
            imem_ack = 1'b0;
            wait_cnt++;
         end
      end else begin
         imem_ack = 1'b0;
         wait_cnt = 0;
      end
   end

   task automatic do_reset();
      rst            = 1'b0;
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      ack_log.delete();
   endtask

   task automatic test_reset();
      logic [15:0] e;
      logic [15:0] nx;
      do_reset();
      lat = 5;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0) begin
         failures++;
         $display("FAIL rst_req got=%b want=0", imem_req);
      end
      checks++;
      if (inst_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_valid got=%b want=0", inst_valid);
      end
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL rst_err got=%b want=0", err);
      end
      rst = 1'b1;
      lat = 0;
      inst_ready = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 16; i++)
         exp_q.push_back(16'(2 * i));
      repeat (6) begin
         @(negedge clk);
         if (inst_valid && inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rst_pop got pc=%h want none", inst_pc);
            end else begin
               e  = exp_q.pop_front();
               nx = e + 16'd2;
               if (inst_pc !== e || inst_data !== data_of(e)
                   || inst_pc_next !== nx) begin
                  failures++;
                  $display("FAIL rst_pop got pc=%h d=%h n=%h want pc=%h d=%h n=%h",
                           inst_pc, inst_data, inst_pc_next, e, data_of(e), nx);
               end
            end
         end
      end
   endtask

   task automatic test_zero_wait();
      logic [15:0] e;
      logic [15:0] nx;
      int cyc[$];
      do_reset();
      lat = 0;
      inst_ready = 1'b1;
      for (int i = 0; i < 16; i++)
         exp_q.push_back(16'(2 * i));
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (inst_valid && inst_ready) begin
            cyc.push_back(c);
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL zw_pop got pc=%h want none", inst_pc);
            end else begin
               e  = exp_q.pop_front();
               nx = e + 16'd2;
               if (inst_pc !== e || inst_data !== data_of(e)
                   || inst_pc_next !== nx) begin
                  failures++;
                  $display("FAIL zw_pop got pc=%h d=%h n=%h want pc=%h d=%h n=%h",
                           inst_pc, inst_data, inst_pc_next, e, data_of(e), nx);
               end
            end
         end
      end
      checks++;
      if (cyc.size() < 3) begin
         failures++;
         $display("FAIL zw_count got=%0d want>=3", cyc.size());
      end else begin
         checks++;
         if (cyc[1] != cyc[0] + 1 || cyc[2] != cyc[1] + 1
             || cyc[0] != 2) begin
            failures++;
            $display("FAIL zw_rate got cycles %0d,%0d,%0d want 2,3,4",
                     cyc[0], cyc[1], cyc[2]);
         end
      end
      inst_ready = 1'b0;
   endtask

   task automatic test_fill();
      logic [15:0] e;
      logic [15:0] nx;
      int req_seen;
      do_reset();
      lat = 3;
      repeat (40) @(negedge clk);
      checks++;
      if (ack_log.size() != 4) begin
         failures++;
         $display("FAIL fill_acks got=%0d want=4", ack_log.size());
      end
      req_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (imem_req !== 1'b0)
            req_seen++;
      end
      checks++;
      if (req_seen != 0 || ack_log.size() != 4) begin
         failures++;
         $display("FAIL fill_noreq got req_cycles=%0d acks=%0d want 0 and 4",
                  req_seen, ack_log.size());
      end
      checks++;
      if (inst_valid !== 1'b1) begin
         failures++;
         $display("FAIL fill_valid got=%b want=1", inst_valid);
      end
      lat = 6;
      for (int i = 0; i < 4; i++)
         exp_q.push_back(16'(2 * i));
      inst_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c != 0)
            @(negedge clk);
         checks++;
         if (!inst_valid || exp_q.size() == 0) begin
            failures++;
            $display("FAIL fill_pop got valid=%b want 1", inst_valid);
         end else begin
            e  = exp_q.pop_front();
            nx = e + 16'd2;
            if (inst_pc !== e || inst_data !== data_of(e)
                || inst_pc_next !== nx) begin
               failures++;
               $display("FAIL fill_pop got pc=%h d=%h n=%h want pc=%h d=%h n=%h",
                        inst_pc, inst_data, inst_pc_next, e, data_of(e), nx);
            end
         end
      end
      @(negedge clk);
      inst_ready = 1'b0;
      checks++;
      if (inst_valid !== 1'b0) begin
         failures++;
         $display("FAIL fill_drained got=%b want=0", inst_valid);
      end
   endtask

   task automatic test_redirect();
      logic [15:0] e;
      logic [15:0] nx;
      int n;
      int early;
      int pops;
      do_reset();
      lat = 4;
      inst_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (imem_req !== 1'b1 && n < 10);
      checks++;
      if (imem_req !== 1'b1) begin
         failures++;
         $display("FAIL rd_req_start got=%b want=1", imem_req);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0100;
      exp_q.delete();
      for (int i = 0; i < 16; i++)
         exp_q.push_back(16'h0100 + 16'(2 * i));
      @(negedge clk);
      redirect_valid = 1'b0;
      early = 0;
      pops  = 0;
      repeat (40) begin
         @(negedge clk);
         if (ack_log.size() < 2 && inst_valid !== 1'b0)
            early++;
         if (inst_valid && inst_ready) begin
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rd_pop got pc=%h want none", inst_pc);
            end else begin
               e  = exp_q.pop_front();
               nx = e + 16'd2;
               if (inst_pc !== e || inst_data !== data_of(e)
                   || inst_pc_next !== nx) begin
                  failures++;
                  $display("FAIL rd_pop got pc=%h d=%h n=%h want pc=%h d=%h n=%h",
                           inst_pc, inst_data, inst_pc_next, e, data_of(e), nx);
               end
            end
         end
      end
      checks++;
      if (early != 0) begin
         failures++;
         $display("FAIL rd_empty got valid_cycles=%0d want=0", early);
      end
      checks++;
      if (ack_log.size() < 2) begin
         failures++;
         $display("FAIL rd_acks got=%0d want>=2", ack_log.size());
      end else if (ack_log[0] !== 16'h0000 || ack_log[1] !== 16'h0100) begin
         failures++;
         $display("FAIL rd_acks got addr %h,%h want 0000,0100",
                  ack_log[0], ack_log[1]);
      end
      checks++;
      if (pops < 2) begin
         failures++;
         $display("FAIL rd_pops got=%0d want>=2", pops);
      end
      inst_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [15:0] e;
      logic [15:0] nx;
      int gaps;
      int pops;
      do_reset();
      lat = 0;
      for (int i = 0; i < 32; i++)
         exp_q.push_back(16'(2 * i));
      repeat (10) @(negedge clk);
      checks++;
      if (ack_log.size() != 4 || imem_req !== 1'b0) begin
         failures++;
         $display("FAIL b2b_full got acks=%0d req=%b want 4 and 0",
                  ack_log.size(), imem_req);
      end
      inst_ready = 1'b1;
      gaps = 0;
      pops = 0;
      repeat (12) begin
         if (pops != 0)
            @(negedge clk);
         if (inst_valid !== 1'b1)
            gaps++;
         if (inst_valid && inst_ready) begin
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL b2b_pop got pc=%h want none", inst_pc);
            end else begin
               e  = exp_q.pop_front();
               nx = e + 16'd2;
               if (inst_pc !== e || inst_data !== data_of(e)
                   || inst_pc_next !== nx) begin
                  failures++;
                  $display("FAIL b2b_pop got pc=%h d=%h n=%h want pc=%h d=%h n=%h",
                           inst_pc, inst_data, inst_pc_next, e, data_of(e), nx);
               end
            end
         end
      end
      checks++;
      if (gaps != 0 || pops != 12) begin
         failures++;
         $display("FAIL b2b_stream got gaps=%0d pops=%0d want 0 and 12",
                  gaps, pops);
      end
      inst_ready = 1'b0;
   endtask

   task automatic test_wrap();
      logic [15:0] e;
      logic [15:0] nx;
      int pops;
      do_reset();
      lat = 0;
      inst_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFE;
      for (int i = 0; i < 16; i++)
         exp_q.push_back(16'hFFFE + 16'(2 * i));
      @(negedge clk);
      redirect_valid = 1'b0;
      pops = 0;
      repeat (8) begin
         @(negedge clk);
         if (inst_valid && inst_ready) begin
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL wrap_pop got pc=%h want none", inst_pc);
            end else begin
               e  = exp_q.pop_front();
               nx = e + 16'd2;
               if (inst_pc !== e || inst_data !== data_of(e)
                   || inst_pc_next !== nx) begin
                  failures++;
                  $display("FAIL wrap_pop got pc=%h d=%h n=%h want pc=%h d=%h n=%h",
                           inst_pc, inst_data, inst_pc_next, e, data_of(e), nx);
               end
            end
         end
      end
      checks++;
      if (pops < 3) begin
         failures++;
         $display("FAIL wrap_pops got=%0d want>=3", pops);
      end
      inst_ready = 1'b0;
   endtask

   task automatic test_align();
      int req_seen;
      do_reset();
      lat = 0;
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0101;
      @(negedge clk);
      redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL align_err got=%b want=1", err);
      end
      req_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (imem_req !== 1'b0)
            req_seen++;
      end
      checks++;
      if (req_seen != 0 || err !== 1'b1) begin
         failures++;
         $display("FAIL align_hold got req_cycles=%0d err=%b want 0 and 1",
                  req_seen, err);
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL align_clear got=%b want=0", err);
      end
`else
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL align_err got=%b want=0", err);
      end
      req_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (imem_req === 1'b1)
            req_seen++;
      end
      checks++;
      if (ack_log.size() == 0 || req_seen == 0) begin
         failures++;
         $display("FAIL align_fetch got acks=%0d req_cycles=%0d want >0",
                  ack_log.size(), req_seen);
      end else if (ack_log[0] !== 16'h0101) begin
         failures++;
         $display("FAIL align_fetch got addr=%h want=0101", ack_log[0]);
      end
`endif
   endtask

   initial begin
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      inst_ready     = 1'b0;
      imem_ack       = 1'b0;
      imem_rdata     = '0;
      test_reset();
      test_zero_wait();
      test_fill();
      test_redirect();
      test_back_to_back();
      test_wrap();
      test_align();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
